// File: rtl/spi_slave.sv
// Mode-0 SPI responder, MSB first, fully oversampled on the local clock.
// A transmit holding register feeds the tx shifter; FILL is sent on underrun.
module spi_slave #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] FILL        = {WIDTH{1'b1}}
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             SCLK,
  input  logic             CS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] txData,
  input  logic             txLoad,
  output logic             txReady,
  output logic [WIDTH-1:0] rxData,
  output logic             arrived,
  output logic             underrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_p0, cs_p0, mosi_p0;
  logic                   sclk_p1, cs_p1;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       rx_shift, tx_shift, hold, tx_next, rx_next;
  logic                   hold_full, reload;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_p0[SYNC_STAGES-1];
  assign cs_s      = cs_p0[SYNC_STAGES-1];
  assign mosi_s    = mosi_p0[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p1;
  assign sclk_fall = ~sclk_s & sclk_p1;
  assign cs_fall   = ~cs_s & cs_p1;
  assign cs_rise   = cs_s & ~cs_p1;
  assign txReady   = ~hold_full;
  // A shifter load always samples the holding register as it stood before this cycle.
  assign tx_next   = hold_full ? hold : FILL;
  assign rx_next   = {rx_shift[WIDTH-2:0], mosi_s};

  // Stage p0: synchronisers, stage p1: previous synchronised sample for edge detection
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sclk_p0 <= '0;
      cs_p0   <= '1;
      mosi_p0 <= '0;
      sclk_p1 <= 1'b0;
      cs_p1   <= 1'b1;
    end else begin
      sclk_p0 <= {sclk_p0[SYNC_STAGES-2:0], SCLK};
      cs_p0   <= {cs_p0[SYNC_STAGES-2:0], CS};
      mosi_p0 <= {mosi_p0[SYNC_STAGES-2:0], MOSI};
      sclk_p1 <= sclk_s;
      cs_p1   <= cs_s;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      reload    <= 1'b0;
      rxData    <= '0;
      arrived   <= 1'b0;
      underrun  <= 1'b0;
      busy      <= 1'b0;
      MISO      <= 1'b0;
    end else begin
      arrived  <= 1'b0;
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= ACTIVE;
            cnt       <= '0;
            reload    <= 1'b0;
            busy      <= 1'b1;
            tx_shift  <= tx_next;
            MISO      <= tx_next[WIDTH-1];
            underrun  <= ~hold_full;
            hold_full <= 1'b0;
          end
        end
        ACTIVE: begin
          // CS takes priority over an SCLK edge seen in the same cycle.
          if (cs_rise) begin
            state    <= IDLE;
            cnt      <= '0;
            reload   <= 1'b0;
            busy     <= 1'b0;
            MISO     <= 1'b0;
            rx_shift <= '0;
          end else if (sclk_rise) begin
            rx_shift <= rx_next;
            if (cnt == CW'(WIDTH-1)) begin
              rxData  <= rx_next;
              arrived <= 1'b1;
              cnt     <= '0;
              reload  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            if (reload) begin
              reload    <= 1'b0;
              tx_shift  <= tx_next;
              MISO      <= tx_next[WIDTH-1];
              underrun  <= ~hold_full;
              hold_full <= 1'b0;
            end else begin
              tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
              MISO     <= tx_shift[WIDTH-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Capture after any consume above so a same-cycle load lands for the next frame.
      if (txLoad && !hold_full) begin
        hold      <= txData;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 0, CPOL=0/CPHA=0, MSB first) for the far end of the AlarmSystem SPI link.
- Oversamples SCLK, CS and MOSI on the local Clock, so the block has no SCLK clock domain.
- Deserialises MOSI into a received byte, flagged by a one-cycle `arrived` pulse.
- Serialises a host-loaded transmit byte onto MISO in the same transfer.

Parameters:
- WIDTH, 8, bits per SPI frame.
- SYNC_STAGES, 2, synchroniser flops on SCLK, CS and MOSI (minimum 2).
- FILL, 8'hFF, byte shifted out when no transmit byte is pending (underrun).

Ports:
- Clock  in  1  system clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from the master; asynchronous to Clock.
- CS  in  1  chip select, active-low, from the master.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data; driven 0 while CS is inactive (no tri-state).
- txData  in  WIDTH  byte to transmit.
- txLoad  in  1  strobe; captures txData when txReady=1.
- txReady  out  1  transmit holding register empty.
- rxData  out  WIDTH  last complete received byte.
- arrived  out  1  one-cycle pulse: rxData was just updated.
- underrun  out  1  one-cycle pulse: FILL was loaded for lack of a pending byte.
- busy  out  1  CS synchronised-active.

Behaviour:
- Reset (async, Reset=0):
  - Outputs: MISO=0, txReady=1, rxData=0, arrived=0, underrun=0, busy=0.
  - Internal: synchronisers=idle (SCLK=0, CS=1), bit counter=0, shift registers=0, state=IDLE.
  - Reset mid-transfer aborts it with no arrived pulse.
- Synchronisation and timing:
  - SCLK, CS and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected from the last two synchronised samples.
  - Requirement: SCLK high and low times ≥ SYNC_STAGES+2 Clock periods.
  - Requirement: CS fall to first SCLK rise ≥ SYNC_STAGES+2 Clock periods.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on synchronised CS fall:
  - bit counter=0, busy=1.
  - tx shift register loaded from the holding register if full, else from FILL with an underrun pulse.
  - txReady=1 on the next cycle.
  - MISO = tx shift MSB from that cycle.
- ACTIVE, synchronised SCLK rise:
  - rx shift <= {rx shift[WIDTH-2:0], MOSI_sync}; bit counter increments.
  - When the count reaches WIDTH: rxData <= assembled byte, arrived=1 for exactly one cycle (the cycle after the edge is detected), counter wraps to 0, a reload flag is set.
- ACTIVE, synchronised SCLK fall:
  - Reload flag set: tx shift loaded as at CS fall (holding or FILL/underrun), flag cleared.
  - Otherwise: tx shift shifts left by one.
  - MISO always equals the tx shift MSB.
- ACTIVE -> IDLE on synchronised CS rise, including mid-frame:
  - Partial rx bits discarded; no arrived pulse.
  - Counter=0, reload flag cleared, busy=0, MISO=0.
  - A byte already moved into the tx shift register is consumed and lost.
  - The holding register is untouched.
- Transmit holding register:
  - txLoad with txReady=1 captures txData; txReady=0 next cycle.
  - txLoad with txReady=0 is ignored; the held byte is kept.
- Same-cycle txLoad and shift-register load:
  - The load samples the holding register first, so it takes FILL if the holding register was empty.
  - The new txData is then captured into the holding register for the next frame.
- Back-to-back frames with CS held low are supported indefinitely. rxData is overwritten each frame; there is no overrun detection.
- CS inactive: SCLK edges and MOSI are ignored.
- Glitch rule: only synchronised edges count; an SCLK and a CS edge seen in the same cycle are resolved CS-first.

Test Plan:
- Single frame: load 8'hA5; master sends 8'h42 at SCLK half-period 4 Clocks -> MISO carries 1,0,1,0,0,1,0,1 sampled on SCLK rises; rxData=8'h42; one arrived pulse; txReady returns 1 after CS fall.
- Back-to-back: load 8'h3C, CS low, master sends 8'hAA; load 8'hC3 during the first frame; master then sends 8'h55 -> two arrived pulses with rxData 8'hAA then 8'h55; MISO bytes 8'h3C then 8'hC3; no underrun.
- Underrun: no load, CS low, master sends 8'h0A -> MISO byte 8'hFF; underrun pulse at CS fall; rxData=8'h0A.
- Abort: CS raised after 5 SCLK rises of 8'hF3 -> no arrived; rxData holds its previous value. Next full frame 8'h72 -> rxData=8'h72; bit count restarted from 0.
- Load contention: txLoad 8'h11 accepted, then txLoad 8'h22 while txReady=0 -> MISO frame shows 8'h11. Separately, txLoad asserted in the CS-fall load cycle with the holding register empty -> that frame sends FILL, the next frame sends the loaded byte.
- Async reset: Reset low mid-frame for 1 Clock -> all outputs at reset values immediately (MISO=0, txReady=1, rxData=0). After Reset high and CS re-asserted, a fresh frame 8'h6B is received correctly.
